// File: rtl/ddr_pkg.sv
// Shared definitions for the arrow-target sequencer: lane indices, FSM
// state encodings and the bit layout of a pattern-table entry.
package ddr_pkg;

  localparam int LANE_LEFT  = 0;
  localparam int LANE_RIGHT = 1;
  localparam int LANE_UP    = 2;
  localparam int LANE_DOWN  = 3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2
  } state_e;

  // Entry layout is {time_ms, lane_mask}: the mask sits in the low bits.
  localparam int ENT_MASK_LSB = 0;

  function automatic int ent_time_lsb(input int lanes);
    return lanes;
  endfunction

endpackage

// File: rtl/ms_timer.sv
// Millisecond timebase: a CLK_PER_MS prescaler feeding a saturating ms counter.
// clr_i restarts both counters; en_i low freezes them mid-count.
module ms_timer #(
  parameter int TIME_W     = 15,
  parameter int CLK_PER_MS = 50000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_i,
  input  logic              en_i,
  output logic [TIME_W-1:0] ms_o,
  output logic              sat_o
);

  localparam int                PRE_W   = $clog2(CLK_PER_MS);
  localparam logic [PRE_W-1:0]  PRE_MAX = PRE_W'(CLK_PER_MS - 1);
  localparam logic [TIME_W-1:0] MS_MAX  = '1;

  logic [PRE_W-1:0]  pre_q;
  logic [TIME_W-1:0] ms_q;

  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      pre_q <= '0;
      ms_q  <= '0;
    end else if (en_i) begin
      if (pre_q == PRE_MAX) begin
        pre_q <= '0;
        if (ms_q != MS_MAX) ms_q <= ms_q + TIME_W'(1);
      end else begin
        pre_q <= pre_q + PRE_W'(1);
      end
    end
  end

  assign ms_o  = ms_q;
  assign sat_o = (ms_q == MS_MAX);

endmodule

// File: rtl/level_sequencer.sv
// Table-driven arrow-target sequencer: replays {time_ms, lane_mask} steps
// against a millisecond timebase, one lane pulse per due step.
module level_sequencer
  import ddr_pkg::*;
#(
  parameter int LANES      = 4,
  parameter int DEPTH      = 32,
  parameter int TIME_W     = 15,
  parameter int CLK_PER_MS = 50000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       pause,
  input  logic                       loop,
  input  logic                       tbl_we,
  input  logic [$clog2(DEPTH)-1:0]   tbl_addr,
  input  logic [TIME_W+LANES-1:0]    tbl_wdata,
  output logic [LANES-1:0]           arrows,
  output logic                       done,
  output logic                       busy,
  output logic [$clog2(DEPTH):0]     step_idx
);

  localparam int             AW       = $clog2(DEPTH);
  localparam int             TIME_LSB = ent_time_lsb(LANES);
  localparam logic [AW:0]    IDX_END  = (AW + 1)'(DEPTH);

  logic [TIME_W+LANES-1:0] tbl_q [DEPTH];

  state_e            state_q;
  logic [AW:0]       idx_q;
  logic [LANES-1:0]  arrows_q;
  logic              done_q;
  logic              restart_q;

  logic [TIME_W+LANES-1:0] entry;
  logic [TIME_W-1:0]       ent_time;
  logic [LANES-1:0]        ent_mask;
  logic [TIME_W-1:0]       ms_cnt;
  logic                    ms_sat;
  logic                    due, go, end_lvl, fire_d, tmr_clr, tmr_en;

  assign entry    = tbl_q[idx_q[AW-1:0]];
  assign ent_time = entry[TIME_LSB +: TIME_W];
  assign ent_mask = entry[ENT_MASK_LSB +: LANES];

  // A looping level restarts exactly like a fresh start request one cycle later.
  assign go      = start | restart_q;
  assign due     = (ent_time <= ms_cnt);
  assign end_lvl = (idx_q == IDX_END) || (due && (ent_mask == '0)) || (ms_sat && !due);
  assign fire_d  = due && (ent_mask != '0);
  assign tmr_clr = go || ((state_q == S_RUN) && end_lvl);
  assign tmr_en  = (state_q == S_RUN);

  ms_timer #(
    .TIME_W     (TIME_W),
    .CLK_PER_MS (CLK_PER_MS)
  ) u_timer (
    .clk   (clk),
    .rst   (rst),
    .clr_i (tmr_clr),
    .en_i  (tmr_en),
    .ms_o  (ms_cnt),
    .sat_o (ms_sat)
  );

  always_ff @(posedge clk) begin
    if (tbl_we && (state_q == S_IDLE)) tbl_q[tbl_addr] <= tbl_wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      arrows_q  <= '0;
      done_q    <= 1'b0;
      restart_q <= 1'b0;
    end else begin
      arrows_q  <= '0;
      done_q    <= 1'b0;
      restart_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q <= S_RUN;
            idx_q   <= '0;
          end
        end
        S_RUN: begin
          if (go) begin
            idx_q <= '0;
          end else if (end_lvl) begin
            done_q <= 1'b1;
            idx_q  <= '0;
            if (loop) restart_q <= 1'b1;
            else      state_q   <= S_IDLE;
          end else begin
            if (fire_d) begin
              arrows_q <= ent_mask;
              idx_q    <= idx_q + (AW + 1)'(1);
            end
            if (pause) state_q <= S_PAUSE;
          end
        end
        S_PAUSE: begin
          if (go) begin
            state_q <= S_RUN;
            idx_q   <= '0;
          end else if (!pause) begin
            state_q <= S_RUN;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign arrows   = arrows_q;
  assign done     = done_q;
  assign busy     = (state_q != S_IDLE);
  assign step_idx = idx_q;

endmodule

// File: tb/tb_level_sequencer.sv
// Directed bench for level_sequencer with a 4-cycle millisecond tick: per-cycle
// checks of arrows/done/busy against hand-computed event tables.
module tb_level_sequencer;
  import ddr_pkg::*;

  localparam int LANES = 4;
  localparam int DEPTH = 32;
  localparam int TW    = 15;
  localparam int CPM   = 4;

  localparam logic [3:0] ML = 4'b0001 << LANE_LEFT;
  localparam logic [3:0] MR = 4'b0001 << LANE_RIGHT;
  localparam logic [3:0] MU = 4'b0001 << LANE_UP;
  localparam logic [3:0] MD = 4'b0001 << LANE_DOWN;

  logic            clk = 1'b0;
  logic            rst, start, pause, loop, tbl_we;
  logic [4:0]      tbl_addr;
  logic [TW+3:0]   tbl_wdata;
  logic [3:0]      arrows;
  logic            done, busy;
  logic [5:0]      step_idx;

  always #5 clk = ~clk;

  level_sequencer #(
    .LANES(LANES), .DEPTH(DEPTH), .TIME_W(TW), .CLK_PER_MS(CPM)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .pause(pause), .loop(loop),
    .tbl_we(tbl_we), .tbl_addr(tbl_addr), .tbl_wdata(tbl_wdata),
    .arrows(arrows), .done(done), .busy(busy), .step_idx(step_idx)
  );

  typedef struct {
    int tbl; int ncyc; int p_from; int p_to; int rs_cyc; int wr_cyc; bit lp; int busy_end;
  } sc_t;
  typedef struct { int sc; int cyc; logic [3:0] arr; logic dn; } ev_t;

  sc_t sc [6];
  ev_t ev [$];
  int  n_cmp = 0;
  int  n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int a, input int t, input logic [3:0] m);
    logic [TW-1:0] tt;
    tt        = TW'(t);
    tbl_we    = 1'b1;
    tbl_addr  = 5'(a);
    tbl_wdata = {tt, m};
    tick();
    tbl_we    = 1'b0;
  endtask

  function automatic logic [3:0] fmask(input int i);
    return 4'((i % 15) + 1);
  endfunction

  task automatic load_tbl(input int id);
    case (id)
      1: begin wr(0, 0, ML); wr(1, 2, MU); wr(2, 5, 4'b0000); end
      2: begin wr(0, 3, MR); wr(1, 3, MD); wr(2, 4, 4'b0000); end
      default: for (int i = 0; i < DEPTH; i++) wr(i, 0, fmask(i));
    endcase
  endtask

  initial begin
    logic [3:0] ea;
    logic       ed;

    // Scenario inputs: table, length, pause window, restart cycle, write cycle, loop, busy end.
    sc[0] = '{1, 26, -1, -1, -1, -1, 1'b0, 22};
    sc[1] = '{2, 20, -1, -1, -1, -1, 1'b0, 18};
    sc[2] = '{1, 46,  4, 23, -1, -1, 1'b0, 42};
    sc[3] = '{1, 32, -1, -1,  6, 12, 1'b0, 28};
    sc[4] = '{3, 38, -1, -1, -1, -1, 1'b0, 34};
    sc[5] = '{1, 45, -1, -1, -1, -1, 1'b1, 1000};

    ev.push_back('{0,  2, ML, 1'b0}); ev.push_back('{0, 10, MU, 1'b0}); ev.push_back('{0, 22, 4'b0, 1'b1});
    ev.push_back('{1, 14, MR, 1'b0}); ev.push_back('{1, 15, MD, 1'b0}); ev.push_back('{1, 18, 4'b0, 1'b1});
    ev.push_back('{2,  2, ML, 1'b0}); ev.push_back('{2, 30, MU, 1'b0}); ev.push_back('{2, 42, 4'b0, 1'b1});
    ev.push_back('{3,  2, ML, 1'b0}); ev.push_back('{3,  8, ML, 1'b0});
    ev.push_back('{3, 16, MU, 1'b0}); ev.push_back('{3, 28, 4'b0, 1'b1});
    for (int i = 0; i < DEPTH; i++) ev.push_back('{4, 2 + i, fmask(i), 1'b0});
    ev.push_back('{4, 34, 4'b0, 1'b1});
    ev.push_back('{5,  2, ML, 1'b0}); ev.push_back('{5, 10, MU, 1'b0}); ev.push_back('{5, 22, 4'b0, 1'b1});
    ev.push_back('{5, 24, ML, 1'b0}); ev.push_back('{5, 32, MU, 1'b0}); ev.push_back('{5, 44, 4'b0, 1'b1});

    rst = 1'b1; start = 1'b0; pause = 1'b0; loop = 1'b0;
    tbl_we = 1'b0; tbl_addr = '0; tbl_wdata = '0;
    tick(); tick();
    chk("reset arrows", {28'd0, arrows}, 32'd0);
    chk("reset done", {31'd0, done}, 32'd0);
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset step_idx", {26'd0, step_idx}, 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("idle busy", {31'd0, busy}, 32'd0);
    end

    for (int s = 0; s < 6; s++) begin
      load_tbl(sc[s].tbl);
      start = 1'b1;
      loop  = sc[s].lp;
      for (int c = 1; c <= sc[s].ncyc; c++) begin
        tick();
        start     = (c == sc[s].rs_cyc);
        pause     = (c >= sc[s].p_from) && (c <= sc[s].p_to);
        tbl_we    = (c == sc[s].wr_cyc);
        tbl_addr  = 5'd1;
        tbl_wdata = {15'd0, MD};
        ea = 4'b0; ed = 1'b0;
        foreach (ev[i]) if (ev[i].sc == s && ev[i].cyc == c) begin ea = ev[i].arr; ed = ev[i].dn; end
        chk($sformatf("s%0d c%0d arrows", s, c), {28'd0, arrows}, {28'd0, ea});
        chk($sformatf("s%0d c%0d done", s, c), {31'd0, done}, {31'd0, ed});
        chk($sformatf("s%0d c%0d busy", s, c), {31'd0, busy}, {31'd0, (c < sc[s].busy_end)});
        if (c == sc[s].rs_cyc) chk($sformatf("s%0d step_idx before restart", s), {26'd0, step_idx}, 32'd1);
        if (c == sc[s].rs_cyc + 1) chk($sformatf("s%0d step_idx after restart", s), {26'd0, step_idx}, 32'd0);
      end
    end

    // Looping level still running: reset lands on the cycle a step would fire.
    rst = 1'b1;
    tick();
    chk("rst-mid arrows", {28'd0, arrows}, 32'd0);
    chk("rst-mid busy", {31'd0, busy}, 32'd0);
    chk("rst-mid done", {31'd0, done}, 32'd0);
    chk("rst-mid step_idx", {26'd0, step_idx}, 32'd0);
    rst = 1'b0; loop = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("post-rst arrows", {28'd0, arrows}, 32'd0);
      chk("post-rst busy", {31'd0, busy}, 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
